// File: rtl/operand_fetch.sv
// Operand-read stage: resolves each uop source from an inline constant, a bypass bus or a
// shared RF read port, with a per-port ready/valid handshake and mispredict squash.
module operand_fetch #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned NUM_RF_RD = 6,
  parameter int unsigned NUM_FWD   = 6,
  parameter int unsigned TAG_W     = 7,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned SQN_W     = 7,
  parameter int unsigned PAYLOAD_W = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS-1:0]                 IN_valid,
  output logic [NUM_PORTS-1:0]                 OUT_inReady,
  input  logic [NUM_PORTS*SQN_W-1:0]           IN_sqN,
  input  logic [NUM_PORTS*NUM_SRC*TAG_W-1:0]   IN_tag,
  input  logic [NUM_PORTS*PAYLOAD_W-1:0]       IN_payload,
  input  logic [NUM_FWD-1:0]                   IN_fwdValid,
  input  logic [NUM_FWD*TAG_W-1:0]             IN_fwdTag,
  input  logic [NUM_FWD*DATA_W-1:0]            IN_fwdData,
  output logic [NUM_RF_RD-1:0]                 OUT_rfReqValid,
  output logic [NUM_RF_RD*(TAG_W-1)-1:0]       OUT_rfReqTag,
  input  logic [NUM_RF_RD*DATA_W-1:0]          IN_rfData,
  input  logic                                 IN_branchTaken,
  input  logic [SQN_W-1:0]                     IN_branchSqN,
  output logic [NUM_PORTS-1:0]                 OUT_valid,
  input  logic [NUM_PORTS-1:0]                 IN_outReady,
  output logic [NUM_PORTS*SQN_W-1:0]           OUT_sqN,
  output logic [NUM_PORTS*PAYLOAD_W-1:0]       OUT_payload,
  output logic [NUM_PORTS*NUM_SRC*DATA_W-1:0]  OUT_src
);

  localparam int unsigned RFI_W = (NUM_RF_RD > 1) ? $clog2(NUM_RF_RD) : 1;

  logic [NUM_PORTS-1:0][SQN_W-1:0]               in_sqn;
  logic [NUM_PORTS-1:0][NUM_SRC-1:0][TAG_W-1:0]  in_tag;
  logic [NUM_PORTS-1:0][PAYLOAD_W-1:0]           in_payload;
  logic [NUM_FWD-1:0][TAG_W-1:0]                 fwd_tag;
  logic [NUM_FWD-1:0][DATA_W-1:0]                fwd_data;
  logic [NUM_RF_RD-1:0][DATA_W-1:0]              rf_data;
  logic [NUM_RF_RD-1:0][TAG_W-2:0]               rf_req_tag;
  logic [NUM_RF_RD-1:0]                          rf_req_valid;

  assign in_sqn       = IN_sqN;
  assign in_tag       = IN_tag;
  assign in_payload   = IN_payload;
  assign fwd_tag      = IN_fwdTag;
  assign fwd_data     = IN_fwdData;
  assign rf_data      = IN_rfData;
  assign OUT_rfReqValid = rf_req_valid;
  assign OUT_rfReqTag   = rf_req_tag;

  // Output register state
  logic [NUM_PORTS-1:0]                          valid_q, valid_d;
  logic [NUM_PORTS-1:0][SQN_W-1:0]               sqn_q, sqn_d;
  logic [NUM_PORTS-1:0][PAYLOAD_W-1:0]           payload_q, payload_d;
  logic [NUM_PORTS-1:0][NUM_SRC-1:0][DATA_W-1:0] src_q, src_d;
  logic [NUM_PORTS-1:0][NUM_SRC-1:0]             is_rf_q, is_rf_d;
  logic [NUM_PORTS-1:0][NUM_SRC-1:0][RFI_W-1:0]  rf_idx_q, rf_idx_d;

  logic [NUM_PORTS-1:0][NUM_SRC-1:0][DATA_W-1:0] res_val;
  logic [NUM_PORTS-1:0][NUM_SRC-1:0]             res_rf;
  logic [NUM_PORTS-1:0][NUM_SRC-1:0][RFI_W-1:0]  alloc_idx;
  logic [NUM_PORTS-1:0][NUM_SRC-1:0][DATA_W-1:0] src_out;
  logic [NUM_PORTS-1:0] in_flush, held_flush, slot_free, rf_grant, accept;

  function automatic logic younger(input logic [SQN_W-1:0] sqn, input logic taken,
                                   input logic [SQN_W-1:0] br_sqn);
    logic [SQN_W-1:0] diff;
    diff = sqn - br_sqn;
    return taken && ($signed(diff) > $signed(SQN_W'(0)));
  endfunction

  // Constant / bypass resolution; anything else falls through to the RF
  always_comb begin : resolve
    logic [TAG_W-1:0] tag;
    logic             hit;
    res_val = '0;
    res_rf  = '0;
    tag     = '0;
    hit     = 1'b0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      for (int s = 0; s < int'(NUM_SRC); s++) begin
        tag = in_tag[p][s];
        hit = 1'b0;
        if (tag[TAG_W-1]) begin
          res_val[p][s] = {{(DATA_W-TAG_W+1){tag[TAG_W-2]}}, tag[TAG_W-2:0]};
        end else begin
          for (int j = 0; j < int'(NUM_FWD); j++) begin
            if (!hit && IN_fwdValid[j] && (fwd_tag[j] == tag)) begin
              hit           = 1'b1;
              res_val[p][s] = fwd_data[j];
            end
          end
          res_rf[p][s] = !hit;
        end
      end
    end
  end

  always_comb begin : flush_slot
    in_flush   = '0;
    held_flush = '0;
    slot_free  = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      in_flush[p]   = younger(in_sqn[p], IN_branchTaken, IN_branchSqN);
      held_flush[p] = younger(sqn_q[p], IN_branchTaken, IN_branchSqN);
      slot_free[p]  = !valid_q[p] || IN_outReady[p] || held_flush[p];
    end
  end

  // Fixed-priority allocator: a port takes RF reads only if all of its operands fit
  always_comb begin : rf_alloc
    int unsigned next_free;
    int unsigned need;
    int unsigned slot;
    next_free    = 0;
    need         = 0;
    slot         = 0;
    rf_grant     = '0;
    alloc_idx    = '0;
    rf_req_valid = '0;
    rf_req_tag   = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      need = 0;
      for (int s = 0; s < int'(NUM_SRC); s++) begin
        need = need + 32'(res_rf[p][s]);
      end
      if (!IN_valid[p] || in_flush[p]) begin
        rf_grant[p] = 1'b1;
      end else if (next_free + need <= NUM_RF_RD) begin
        rf_grant[p] = 1'b1;
        slot        = next_free;
        for (int s = 0; s < int'(NUM_SRC); s++) begin
          if (res_rf[p][s]) begin
            alloc_idx[p][s] = RFI_W'(slot);
            if (slot_free[p]) begin
              rf_req_valid[RFI_W'(slot)] = 1'b1;
              rf_req_tag[RFI_W'(slot)]   = in_tag[p][s][TAG_W-2:0];
            end
            slot = slot + 1;
          end
        end
        next_free = next_free + need;
      end
    end
  end

  assign OUT_inReady = slot_free & rf_grant;
  assign accept      = IN_valid & OUT_inReady & ~in_flush;

  // Next state: accept, drain/flush, or stall (freeze RF data into the operand register)
  always_comb begin : next_state
    valid_d   = valid_q;
    sqn_d     = sqn_q;
    payload_d = payload_q;
    src_d     = src_q;
    is_rf_d   = is_rf_q;
    rf_idx_d  = rf_idx_q;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if (accept[p]) begin
        valid_d[p]   = 1'b1;
        sqn_d[p]     = in_sqn[p];
        payload_d[p] = in_payload[p];
        src_d[p]     = res_val[p];
        is_rf_d[p]   = res_rf[p];
        rf_idx_d[p]  = alloc_idx[p];
      end else if (valid_q[p] && (held_flush[p] || IN_outReady[p])) begin
        valid_d[p] = 1'b0;
        is_rf_d[p] = '0;
      end else if (valid_q[p]) begin
        for (int s = 0; s < int'(NUM_SRC); s++) begin
          if (is_rf_q[p][s]) begin
            src_d[p][s] = rf_data[rf_idx_q[p][s]];
          end
        end
        is_rf_d[p] = '0;
      end
    end
    if (rst) begin
      valid_d = '0;
      is_rf_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    valid_q   <= valid_d;
    sqn_q     <= sqn_d;
    payload_q <= payload_d;
    src_q     <= src_d;
    is_rf_q   <= is_rf_d;
    rf_idx_q  <= rf_idx_d;
  end

  always_comb begin : src_mux
    src_out = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      for (int s = 0; s < int'(NUM_SRC); s++) begin
        src_out[p][s] = is_rf_q[p][s] ? rf_data[rf_idx_q[p][s]] : src_q[p][s];
      end
    end
  end

  assign OUT_valid   = valid_q;
  assign OUT_sqN     = sqn_q;
  assign OUT_payload = payload_q;
  assign OUT_src     = src_out;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vector table, hand sequences, and a randomized run
// checked against a transaction-level model with a simulated register file.
module tb_operand_fetch;
  localparam int NP = 4, NS = 2, NRF = 6, NFWD = 6, TW = 7, DW = 32, SW = 7, PW = 64;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0] in_valid, in_ready, out_valid, out_ready;
  logic [NP-1:0][SW-1:0] in_sqn, out_sqn;
  logic [NP-1:0][NS-1:0][TW-1:0] in_tag;
  logic [NP-1:0][PW-1:0] in_payload, out_payload;
  logic [NFWD-1:0] fwd_valid;
  logic [NFWD-1:0][TW-1:0] fwd_tag;
  logic [NFWD-1:0][DW-1:0] fwd_data;
  logic [NRF-1:0] rf_req_valid;
  logic [NRF-1:0][TW-2:0] rf_req_tag;
  logic [NRF-1:0][DW-1:0] rf_data;
  logic br_taken;
  logic [SW-1:0] br_sqn;
  logic [NP-1:0][NS-1:0][DW-1:0] out_src;

  operand_fetch dut (
    .clk(clk), .rst(rst), .IN_valid(in_valid), .OUT_inReady(in_ready), .IN_sqN(in_sqn),
    .IN_tag(in_tag), .IN_payload(in_payload), .IN_fwdValid(fwd_valid), .IN_fwdTag(fwd_tag),
    .IN_fwdData(fwd_data), .OUT_rfReqValid(rf_req_valid), .OUT_rfReqTag(rf_req_tag),
    .IN_rfData(rf_data), .IN_branchTaken(br_taken), .IN_branchSqN(br_sqn),
    .OUT_valid(out_valid), .IN_outReady(out_ready), .OUT_sqN(out_sqn),
    .OUT_payload(out_payload), .OUT_src(out_src)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // model state
  logic [31:0] rf_mem [64];
  logic [NP-1:0] m_valid;
  logic [SW-1:0] m_sqn [NP];
  logic [PW-1:0] m_pay [NP];
  logic [DW-1:0] m_src [NP][NS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic idle();
    rst = 1'b0; in_valid = '0; in_sqn = '0; in_tag = '0; in_payload = '0;
    fwd_valid = '0; fwd_tag = '0; fwd_data = '0; rf_data = '0;
    br_taken = 1'b0; br_sqn = '0; out_ready = '1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic younger(input logic [6:0] s, input logic taken, input logic [6:0] b);
    int d;
    d = (int'(s) - int'(b) + 128) % 128;
    return taken && (d >= 1) && (d <= 63);
  endfunction

  function automatic logic [31:0] sext6(input logic [5:0] v);
    int x;
    x = int'(v);
    if (x >= 32) x = x - 64;
    return 32'(x);
  endfunction

  function automatic void resolve(input logic [6:0] t, output logic [31:0] v, output logic is_rf);
    v = '0;
    is_rf = 1'b0;
    if (t[6]) v = sext6(t[5:0]);
    else begin
      is_rf = 1'b1;
      for (int j = NFWD - 1; j >= 0; j--)
        if (fwd_valid[j] && fwd_tag[j] == t) begin v = fwd_data[j]; is_rf = 1'b0; end
    end
  endfunction

  typedef struct {
    logic [6:0] t0, t1;
    logic f0v; logic [6:0] f0t; logic [31:0] f0d;
    logic f1v; logic [6:0] f1t; logic [31:0] f1d;
    logic [5:0] ereq; logic [5:0] etag; logic [31:0] e0, e1;
  } vec_t;
  vec_t vecs [8];

  task automatic run_vectors();
    vecs[0] = '{7'h7F, 7'h05, 1'b1, 7'h05, 32'hDEADBEEF, 1'b0, 7'h00, 32'h0, 6'b000000, 6'h00, 32'hFFFFFFFF, 32'hDEADBEEF};
    vecs[1] = '{7'h40, 7'h3F, 1'b0, 7'h00, 32'h0, 1'b0, 7'h00, 32'h0, 6'b000001, 6'h3F, 32'h0, 32'h100};
    vecs[2] = '{7'h41, 7'h60, 1'b0, 7'h00, 32'h0, 1'b0, 7'h00, 32'h0, 6'b000000, 6'h00, 32'h1, 32'hFFFFFFE0};
    vecs[3] = '{7'h03, 7'h04, 1'b0, 7'h00, 32'h0, 1'b0, 7'h00, 32'h0, 6'b000011, 6'h03, 32'h100, 32'h101};
    vecs[4] = '{7'h09, 7'h09, 1'b1, 7'h09, 32'hA, 1'b1, 7'h09, 32'hB, 6'b000000, 6'h00, 32'hA, 32'hA};
    vecs[5] = '{7'h09, 7'h02, 1'b0, 7'h09, 32'hA, 1'b1, 7'h09, 32'hB, 6'b000001, 6'h02, 32'hB, 32'h100};
    vecs[6] = '{7'h05, 7'h05, 1'b0, 7'h00, 32'h0, 1'b0, 7'h00, 32'h0, 6'b000011, 6'h05, 32'h100, 32'h101};
    vecs[7] = '{7'h12, 7'h13, 1'b1, 7'h13, 32'hC, 1'b1, 7'h12, 32'hD, 6'b000000, 6'h00, 32'hD, 32'hC};
    for (int i = 0; i < 8; i++) begin
      idle();
      in_valid[0] = 1'b1; in_sqn[0] = 7'(i);
      in_tag[0][0] = vecs[i].t0; in_tag[0][1] = vecs[i].t1;
      fwd_valid[0] = vecs[i].f0v; fwd_tag[0] = vecs[i].f0t; fwd_data[0] = vecs[i].f0d;
      fwd_valid[1] = vecs[i].f1v; fwd_tag[1] = vecs[i].f1t; fwd_data[1] = vecs[i].f1d;
      #1;
      chk("vec_ready", in_ready[0], 1'b1);
      chk("vec_rfreq", rf_req_valid, vecs[i].ereq);
      if (vecs[i].ereq[0]) chk("vec_rftag", rf_req_tag[0], vecs[i].etag);
      step();
      in_valid = '0;
      for (int r = 0; r < NRF; r++) rf_data[r] = 32'h100 + 32'(r);
      #1;
      chk("vec_valid", out_valid, 4'b0001);
      chk("vec_src0", out_src[0][0], vecs[i].e0);
      chk("vec_src1", out_src[0][1], vecs[i].e1);
      step();
    end
  endtask

  task automatic run_directed();
    // RF read on port 1
    idle(); in_valid = 4'b0010; in_tag[1][0] = 7'd3; in_tag[1][1] = 7'd4;
    #1;
    chk("rf_req", rf_req_valid, 6'b000011);
    chk("rf_tag0", rf_req_tag[0], 6'd3);
    chk("rf_tag1", rf_req_tag[1], 6'd4);
    step(); in_valid = '0; rf_data[0] = 32'h11; rf_data[1] = 32'h22;
    #1;
    chk("rf_valid", out_valid, 4'b0010);
    chk("rf_src0", out_src[1][0], 32'h11);
    chk("rf_src1", out_src[1][1], 32'h22);
    step();
    // oversubscription: 8 RF reads against 6 ports
    idle(); in_valid = 4'hF;
    for (int p = 0; p < NP; p++) begin
      in_tag[p][0] = 7'(16 + 2 * p); in_tag[p][1] = 7'(17 + 2 * p);
    end
    #1;
    chk("over_ready", in_ready, 4'b0111);
    chk("over_req", rf_req_valid, 6'b111111);
    step(); in_valid = 4'b1000;
    #1;
    chk("over_ready3", in_ready[3], 1'b1);
    chk("over_req3", rf_req_valid, 6'b000011);
    chk("over_tag3", {rf_req_tag[1], rf_req_tag[0]}, {6'd23, 6'd22});
    step(); in_valid = '0;
    for (int r = 0; r < NRF; r++) rf_data[r] = 32'h200 + 32'(r);
    #1;
    chk("over_valid", out_valid, 4'b1000);
    chk("over_src", {out_src[3][1], out_src[3][0]}, {32'h201, 32'h200});
    step();
    // stall capture
    idle(); in_valid = 4'b0001; in_tag[0][0] = 7'd3; in_tag[0][1] = 7'd4;
    step(); in_valid = '0; out_ready = '0; rf_data[0] = 32'h100; rf_data[1] = 32'h101;
    #1;
    chk("stall_src0", {out_src[0][1], out_src[0][0]}, {32'h101, 32'h100});
    for (int k = 0; k < 3; k++) begin
      step();
      for (int r = 0; r < NRF; r++) rf_data[r] = $urandom;
      #1;
      chk("stall_valid", out_valid[0], 1'b1);
      chk("stall_src", {out_src[0][1], out_src[0][0]}, {32'h101, 32'h100});
      chk("stall_noreq", rf_req_valid, 6'b0);
    end
    out_ready = '1; step();
    chk("stall_drain", out_valid, 4'b0000);
    // flush: held 12 and 9, incoming 11, branch 10
    idle(); in_valid = 4'b0011; in_sqn[0] = 7'd12; in_sqn[1] = 7'd9;
    in_tag[0] = {7'h7F, 7'h7F}; in_tag[1] = {7'h7F, 7'h7F};
    step();
    in_valid = 4'b0100; in_sqn[2] = 7'd11; in_tag[2][0] = 7'd3; in_tag[2][1] = 7'd4;
    out_ready = '0; br_taken = 1'b1; br_sqn = 7'd10;
    #1;
    chk("flush_noreq", rf_req_valid, 6'b0);
    step(); in_valid = '0; br_taken = 1'b0;
    #1;
    chk("flush_valid", out_valid, 4'b0010);
    chk("flush_sqn", out_sqn[1], 7'd9);
    out_ready = '1; step();
    // reset with all slots full and stalled
    idle(); in_valid = 4'hF;
    for (int p = 0; p < NP; p++) in_tag[p] = {7'h41, 7'h7F};
    step(); in_valid = '0; out_ready = '0;
    step();
    chk("pre_rst_valid", out_valid, 4'hF);
    rst = 1'b1; step(); rst = 1'b0;
    #1;
    chk("rst_valid", out_valid, 4'h0);
    in_valid = 4'hF;
    #1;
    chk("rst_ready", in_ready, 4'hF);
    in_valid = '0; out_ready = '1; step();
  endtask

  task automatic run_random(input int n);
    logic [NRF-1:0] pend_v, e_v;
    logic [5:0] pend_t [NRF];
    logic [5:0] e_t [NRF];
    logic [NP-1:0] e_acc, nxt_valid;
    logic [31:0] n_src [NP][NS];
    logic [31:0] n_val [NS];
    logic n_rf [NS];
    int nxt, need, k;
    logic free;
    idle(); rst = 1'b1; step(); rst = 1'b0;
    m_valid = '0; pend_v = '0;
    for (int i = 0; i < NRF; i++) pend_t[i] = '0;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NRF; i++) rf_data[i] = pend_v[i] ? rf_mem[pend_t[i]] : $urandom;
      #1;
      chk("rnd_valid", out_valid, m_valid);
      for (int p = 0; p < NP; p++) if (m_valid[p]) begin
        chk("rnd_sqn", out_sqn[p], m_sqn[p]);
        chk("rnd_payload", out_payload[p], m_pay[p]);
        for (int s = 0; s < NS; s++) chk("rnd_src", out_src[p][s], m_src[p][s]);
      end
      rst = ($urandom % 97) == 0;
      br_taken = ($urandom % 6) == 0; br_sqn = 7'($urandom);
      for (int p = 0; p < NP; p++) begin
        in_valid[p] = ($urandom % 4) != 0; in_sqn[p] = 7'($urandom);
        in_payload[p] = {$urandom, $urandom}; out_ready[p] = ($urandom % 10) < 7;
        for (int s = 0; s < NS; s++)
          in_tag[p][s] = (($urandom % 5) == 0) ? {1'b1, 6'($urandom)} : 7'($urandom % 16);
      end
      for (int j = 0; j < NFWD; j++) begin
        fwd_valid[j] = 1'($urandom); fwd_tag[j] = 7'($urandom % 16); fwd_data[j] = $urandom;
      end
      #1;
      e_v = '0; e_acc = '0; nxt = 0;
      for (int i = 0; i < NRF; i++) e_t[i] = '0;
      for (int p = 0; p < NP; p++) begin
        for (int s = 0; s < NS; s++) n_src[p][s] = '0;
        free = !m_valid[p] || out_ready[p] || younger(m_sqn[p], br_taken, br_sqn);
        if (in_valid[p] && !younger(in_sqn[p], br_taken, br_sqn)) begin
          need = 0;
          for (int s = 0; s < NS; s++) begin
            resolve(in_tag[p][s], n_val[s], n_rf[s]);
            if (n_rf[s]) need++;
          end
          if (nxt + need <= NRF) begin
            chk("rnd_ready", in_ready[p], free);
            if (free) begin
              e_acc[p] = 1'b1; k = nxt;
              for (int s = 0; s < NS; s++) begin
                if (n_rf[s]) begin
                  e_v[k] = 1'b1; e_t[k] = in_tag[p][s][5:0];
                  n_src[p][s] = rf_mem[in_tag[p][s][5:0]]; k++;
                end else n_src[p][s] = n_val[s];
              end
            end
            nxt = nxt + need;
          end else chk("rnd_ready", in_ready[p], 1'b0);
        end
      end
      chk("rnd_rfreq", rf_req_valid, e_v);
      for (int i = 0; i < NRF; i++) if (e_v[i]) chk("rnd_rftag", rf_req_tag[i], e_t[i]);
      for (int p = 0; p < NP; p++) begin
        nxt_valid[p] = m_valid[p];
        if (e_acc[p]) nxt_valid[p] = 1'b1;
        else if (m_valid[p] && (out_ready[p] || younger(m_sqn[p], br_taken, br_sqn)))
          nxt_valid[p] = 1'b0;
      end
      if (rst) nxt_valid = '0;
      pend_v = e_v; pend_t = e_t;
      step();
      for (int p = 0; p < NP; p++) if (e_acc[p]) begin
        m_sqn[p] = in_sqn[p]; m_pay[p] = in_payload[p];
        for (int s = 0; s < NS; s++) m_src[p][s] = n_src[p][s];
      end
      m_valid = nxt_valid;
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rf_mem[i] = $urandom;
    idle(); rst = 1'b1;
    step(); rst = 1'b0;
    chk("reset_valid", out_valid, 4'h0);
    chk("reset_rfreq", rf_req_valid, 6'h0);
    run_vectors();
    run_directed();
    run_random(3000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Parametrised operand-read stage between the issue queues and the execution units. It supersedes the fixed-port load stage. It resolves each source operand of up to NUM_PORTS issued uops from one of three places, in priority order: inline constant, bypass bus, or register file. Register-file read ports are shared across all issue ports by a fixed-priority allocator, and each port gets a ready/valid handshake in place of a bare stall. Branch mispredicts squash uops both at the input and in the output register.

## Interface
- NUM_PORTS, 4, issue/execute channels
- NUM_SRC, 2, source operands per uop
- NUM_RF_RD, 6, shared register-file read ports (1..NUM_PORTS*NUM_SRC)
- NUM_FWD, 6, bypass buses
- TAG_W, 7, operand tag width; MSB set = inline constant
- DATA_W, 32, operand width
- SQN_W, 7, sequence number width
- PAYLOAD_W, 64, opaque uop payload (opcode, imm, fu, fetch info), passed through

Ports, all vectors flattened with port-major packing:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- IN_valid  in  NUM_PORTS  issued uop valid
- OUT_inReady  out  NUM_PORTS  uop accepted this cycle when IN_valid is also high
- IN_sqN  in  NUM_PORTS*SQN_W  uop sequence number
- IN_tag  in  NUM_PORTS*NUM_SRC*TAG_W  source tags
- IN_payload  in  NUM_PORTS*PAYLOAD_W  pass-through payload
- IN_fwdValid  in  NUM_FWD  bypass bus valid
- IN_fwdTag  in  NUM_FWD*TAG_W  bypass destination tag
- IN_fwdData  in  NUM_FWD*DATA_W  bypass result
- OUT_rfReqValid  out  NUM_RF_RD  RF read request valid
- OUT_rfReqTag  out  NUM_RF_RD*(TAG_W-1)  RF read address
- IN_rfData  in  NUM_RF_RD*DATA_W  RF read data, valid the cycle after its request
- IN_branchTaken  in  1  mispredict flush
- IN_branchSqN  in  SQN_W  sqN of the mispredicted branch
- OUT_valid  out  NUM_PORTS  output uop valid
- IN_outReady  in  NUM_PORTS  execution unit accepts the output uop
- OUT_sqN  out  NUM_PORTS*SQN_W  output sequence number
- OUT_payload  out  NUM_PORTS*PAYLOAD_W  output payload
- OUT_src  out  NUM_PORTS*NUM_SRC*DATA_W  resolved operands

## Operation
**Operand resolution.** Each operand (port p, src s) is resolved combinationally in this priority order:
1. **Constant.** If tag[TAG_W-1] is set, the operand is tag[TAG_W-2:0] sign-extended to DATA_W.
2. **Bypass.** Otherwise, if any IN_fwdValid[j] is set with IN_fwdTag[j] equal to the tag, use IN_fwdData of the lowest such j.
3. **Register file.** Otherwise the operand needs an RF read.

**RF port allocator.** RF-needing operands of valid, not-flushed uops are walked in order (p0s0, p0s1, p1s0, …). Each gets the next free RF port, tag[TAG_W-2:0]. A port p is granted only if all of its RF-needing operands receive a port. If it is not granted, its partial allocation is released and later ports may use those RF ports.

**Slot-free condition.** Port p's slot is free when !OUT_valid[p], or IN_outReady[p], or the held uop is being flushed.

**Ready.** OUT_inReady[p] = slot free AND RF granted. OUT_inReady may depend combinationally on IN_valid, IN_tag, IN_fwd* and IN_outReady. It must not depend on IN_rfData.

**Flush.** A uop is younger than the branch when IN_branchTaken is set and $signed(sqN − IN_branchSqN) > 0.
- A younger uop at the input is not latched, and no RF port is allocated to it.
- A younger uop held in the output register is cleared at the clock edge.

**Output register.** On accept, the register latches sqN, payload, resolved constant/bypass operands, and per-operand isRF flags plus RF port index.
- OUT_src selects IN_rfData[index] for operands whose isRF flag is set, otherwise the latched value.
- On a stall (OUT_valid && !IN_outReady), at the edge: capture IN_rfData into the operand register and clear all isRF flags. Operands therefore stay stable with no RF re-read.
- If the output is accepted with no new input, OUT_valid drops.

## Timing
- Latency is 1 cycle: a uop accepted at edge N has OUT_valid high during cycle N+1, with its RF data.
- Throughput is 1 uop per port per cycle, including back-to-back accepts while the output drains.
- OUT_rfReqValid is high only in the cycle a uop is accepted for that port.
- Simultaneous accept and flush of the same input uop: the flush wins; nothing is latched and no RF port is consumed.
- A held uop that is stalled and flushed in the same cycle is cleared; OUT_valid = 0 next cycle.
- Reset values: OUT_valid = 0, OUT_rfReqValid = 0, all isRF flags = 0. Data outputs are don't-care.
- Reset asserted mid-operation empties all slots at the next edge.

## Test plan
- **Constant and bypass.** Port0 tags {7'h7F, 7'h05}, fwd0 = {tag 5, data 0xDEAD_BEEF}, all ports otherwise idle → no RF request; next cycle OUT_src = {0xFFFF_FFFF, 0xDEAD_BEEF}, OUT_valid[0] = 1.
- **RF read.** Port1 tags {3, 4}, no bypass → rfReq ports 0/1 carry tags 3/4; next cycle IN_rfData = 0x11/0x22 appears on OUT_src[1].
- **Oversubscription.** NUM_RF_RD = 6; all 4 ports valid, each needing 2 RF reads → OUT_inReady = 4'b0111. Port3 is accepted on the following cycle.
- **Stall capture.** Accept an RF uop, then hold IN_outReady low for 3 cycles while IN_rfData changes to garbage → OUT_src keeps the first-cycle data; no rfReq is issued.
- **Flush.** IN_branchSqN = 10 and taken, with input sqN 11 and held sqN 12 and 9 → sqN 11 is not latched; held 12 is cleared; held 9 is kept.
- **Reset.** Assert rst with all ports full and stalled → OUT_valid = 0 next cycle; OUT_inReady = 1 for every valid input uop that the RF allocator grants.
